// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the multi-line I2S receiver: FSM encoding, timing
// mode constants and the elaboration-time slot-size check.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } state_t;

  localparam int MODE_LJ      = 0;  // MSB on the WS edge clock
  localparam int MODE_I2S_STD = 1;  // MSB one clock after the WS edge

  // Slot position of the first captured (MSB) bit for a timing mode.
  function automatic int data_offset(input int mode);
    return (mode != MODE_LJ) ? 1 : 0;
  endfunction

  // The whole sample window must fit inside one slot.
  function automatic bit slot_fits(input int slot_bits, input int datawidth, input int mode);
    return slot_bits >= (datawidth + data_offset(mode));
  endfunction

endpackage

// File: rtl/i2s_line_shifter.sv
// Per-line capture: one left and one right MSB-first shift register fed by a
// single DATA pin. The next-state words are exported so the top can latch a
// frame in the same cycle the last bit arrives.
module i2s_line_shifter
  import i2s_rx_pkg::*;
#(
  parameter int DATAWIDTH = 24
) (
  input  logic                 clk_mic,
  input  logic                 rst_mic,
  input  logic                 cap_en,
  input  logic                 slot_sel,  // 0 = left, 1 = right
  input  logic                 din,
  output logic [DATAWIDTH-1:0] l_nxt,
  output logic [DATAWIDTH-1:0] r_nxt
);

  logic [DATAWIDTH-1:0] sr_l;
  logic [DATAWIDTH-1:0] sr_r;

  // Shift the selected slot's register left, new bit entering the LSB.
  always_comb begin
    l_nxt = sr_l;
    r_nxt = sr_r;
    if (cap_en && !slot_sel) l_nxt = DATAWIDTH'({sr_l, din});
    if (cap_en &&  slot_sel) r_nxt = DATAWIDTH'({sr_r, din});
  end

  // Shift register state.
  always_ff @(posedge clk_mic) begin
    if (rst_mic) begin
      sr_l <= '0;
      sr_r <= '0;
    end else begin
      sr_l <= l_nxt;
      sr_r <= r_nxt;
    end
  end

endmodule

// File: rtl/i2s_array_rx.sv
// Multi-line I2S / left-justified receiver running on the mic bit clock.
// Tracks slot position from the shared WS, frames left/right slots with an
// FSM, flags malformed slots, and publishes all lines of a frame at once.
module i2s_array_rx
  import i2s_rx_pkg::*;
#(
  parameter int DATAWIDTH = 24,
  parameter int SLOT_BITS = 32,
  parameter int NUM_LINES = 4,
  parameter int MODE_I2S  = 1
) (
  input  logic                           clk_mic,
  input  logic                           rst_mic,
  input  logic                           en,
  input  logic                           WS,
  input  logic [NUM_LINES-1:0]           DATA,
  output logic [NUM_LINES*DATAWIDTH-1:0] L_DATA,
  output logic [NUM_LINES*DATAWIDTH-1:0] R_DATA,
  output logic                           sample_vld,
  output logic                           frame_err,
  output logic [15:0]                    frame_cnt
);

  localparam int D  = data_offset(MODE_I2S);
  localparam int PW = $clog2(SLOT_BITS + 1);

  localparam logic [PW-1:0] POS_MAX   = PW'(SLOT_BITS);
  localparam logic [PW-1:0] POS_END   = PW'(SLOT_BITS - 1);
  localparam logic [PW-1:0] POS_FIRST = PW'(D);
  localparam logic [PW-1:0] POS_LAST  = PW'(D + DATAWIDTH - 1);
  localparam logic [PW-1:0] WIN_LEN   = PW'(DATAWIDTH);

  if (!slot_fits(SLOT_BITS, DATAWIDTH, MODE_I2S)) begin : g_bad_cfg
    $error("i2s_array_rx: SLOT_BITS cannot hold DATAWIDTH bits in this mode");
  end

  logic          ws_d;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_now;
  logic [PW-1:0] win_off;
  logic          fall, rise, ws_edge;
  logic          in_win, cap_en, err, done;
  state_t        state, state_nxt;

  logic [NUM_LINES-1:0][DATAWIDTH-1:0] l_word;
  logic [NUM_LINES-1:0][DATAWIDTH-1:0] r_word;

  // WS edge detect and slot position; pos saturates so a stuck WS cannot wrap.
  always_comb begin
    fall    = ws_d & ~WS;
    rise    = ~ws_d & WS;
    ws_edge = fall | rise;
    if (ws_edge)             pos_now = '0;
    else if (pos >= POS_MAX) pos_now = POS_MAX;
    else                     pos_now = pos + 1'b1;
    // Offset wraps high below the window start, so one compare covers both ends.
    win_off = pos_now - POS_FIRST;
    in_win  = win_off < WIN_LEN;
  end

  // Framing FSM: next state, error and frame-complete decisions.
  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    done      = 1'b0;
    if (!en) begin
      state_nxt = SYNC_WAIT;
    end else begin
      case (state)
        SYNC_WAIT: if (fall) state_nxt = LEFT;
        LEFT: begin
          if (fall || (ws_edge && pos != POS_END) || (!ws_edge && pos >= POS_END))
            err = 1'b1;
          else if (rise)
            state_nxt = RIGHT;
        end
        RIGHT: begin
          if (rise || (ws_edge && pos != POS_END) || (!ws_edge && pos >= POS_END))
            err = 1'b1;
          else if (fall)
            state_nxt = LEFT;
          else if (pos_now == POS_LAST)
            done = 1'b1;
        end
        default: state_nxt = SYNC_WAIT;
      endcase
      // A fall that breaks the frame is also the start of the next one.
      if (err) state_nxt = fall ? LEFT : SYNC_WAIT;
    end
    cap_en = en && in_win && (state_nxt != SYNC_WAIT);
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    i2s_line_shifter #(
      .DATAWIDTH(DATAWIDTH)
    ) u_line (
      .clk_mic (clk_mic),
      .rst_mic (rst_mic),
      .cap_en  (cap_en),
      .slot_sel(WS),
      .din     (DATA[i]),
      .l_nxt   (l_word[i]),
      .r_nxt   (r_word[i])
    );
  end

  // WS history, slot position and FSM state.
  always_ff @(posedge clk_mic) begin
    if (rst_mic) begin
      ws_d  <= 1'b0;
      pos   <= '0;
      state <= SYNC_WAIT;
    end else begin
      ws_d  <= WS;
      pos   <= pos_now;
      state <= state_nxt;
    end
  end

  // Output strobes, frame latch and valid-frame counter.
  always_ff @(posedge clk_mic) begin
    if (rst_mic) begin
      L_DATA     <= '0;
      R_DATA     <= '0;
      sample_vld <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      sample_vld <= done;
      frame_err  <= err;
      if (done) begin
        L_DATA    <= l_word;
        R_DATA    <= r_word;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_array_rx.sv
// Bench for i2s_array_rx: an I2S-mode and a left-justified instance share one
// WS/DATA stream. A frame-level model (slot run lengths + per-slot bit arrays)
// predicts every output each cycle; literal checks pin the model.
module tb_i2s_array_rx;

  localparam int SB = 32;
  localparam int DW = 24;
  localparam int NL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic ws  = 1'b0;
  logic [NL-1:0] data = '0;

  logic [NL*DW-1:0] l_a, r_a, l_b, r_b;
  logic vld_a, err_a, vld_b, err_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  i2s_array_rx #(.DATAWIDTH(DW), .SLOT_BITS(SB), .NUM_LINES(NL), .MODE_I2S(1)) u_i2s (
    .clk_mic(clk), .rst_mic(rst), .en(en), .WS(ws), .DATA(data),
    .L_DATA(l_a), .R_DATA(r_a), .sample_vld(vld_a), .frame_err(err_a), .frame_cnt(cnt_a));

  i2s_array_rx #(.DATAWIDTH(DW), .SLOT_BITS(SB), .NUM_LINES(NL), .MODE_I2S(0)) u_lj (
    .clk_mic(clk), .rst_mic(rst), .en(en), .WS(ws), .DATA(data),
    .L_DATA(l_b), .R_DATA(r_b), .sample_vld(vld_b), .frame_err(err_b), .frame_cnt(cnt_b));

  int n_chk = 0, n_pass = 0;
  int pulses_vld_a = 0, pulses_err_a = 0, pulses_vld_b = 0, pulses_err_b = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- model ----------------
  // Index 0 = I2S instance (first bit at slot position 1), 1 = LJ (position 0).
  logic [NL-1:0]    bits [2][SB];
  logic             m_ws;
  int               run;
  bit               locked;
  bit               chk_on = 0;
  logic [NL*DW-1:0] e_l [2];
  logic [NL*DW-1:0] e_r [2];
  logic [15:0]      e_cnt [2];
  logic             e_vld [2];
  logic             e_err;

  function automatic logic [NL*DW-1:0] gather(input int slot, input int off);
    logic [NL*DW-1:0] w = '0;
    for (int ln = 0; ln < NL; ln++)
      for (int k = 0; k < DW; k++)
        w[ln*DW + DW-1-k] = bits[slot][off+k][ln];
    return w;
  endfunction

  task automatic model_update(input logic w, input logic [NL-1:0] d);
    bit edge_s, fall_s;
    int run_now, off;
    if (rst) begin
      m_ws = 0; run = 0; locked = 0; e_err = 0; chk_on = 1;
      for (int k = 0; k < 2; k++) begin
        e_l[k] = '0; e_r[k] = '0; e_cnt[k] = '0; e_vld[k] = 0;
      end
      return;
    end
    edge_s  = (w != m_ws);
    fall_s  = m_ws && !w;
    run_now = edge_s ? 0 : ((run + 1 > SB) ? SB : run + 1);
    e_vld[0] = 0; e_vld[1] = 0; e_err = 0;
    if (!en) locked = 0;
    else if (locked) begin
      // A slot is good only if it lasts exactly SB clocks.
      if (edge_s ? (run != SB-1) : (run + 1 >= SB)) begin
        e_err = 1; locked = fall_s;
      end
    end else if (fall_s) locked = 1;
    if (en && locked && run_now < SB) bits[w ? 1 : 0][run_now] = d;
    if (en && locked && w && !e_err)
      for (int k = 0; k < 2; k++) begin
        off = (k == 0) ? 1 : 0;
        if (run_now == off + DW - 1) begin
          e_vld[k] = 1;
          e_l[k]   = gather(0, off);
          e_r[k]   = gather(1, off);
          e_cnt[k] = e_cnt[k] + 16'd1;
        end
      end
    m_ws = w; run = run_now;
  endtask

  // Single compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("vld_i2s", vld_a, e_vld[0]);  cmp("vld_lj", vld_b, e_vld[1]);
      cmp("err_i2s", err_a, e_err);     cmp("err_lj", err_b, e_err);
      cmp("L_i2s", l_a, e_l[0]);        cmp("L_lj", l_b, e_l[1]);
      cmp("R_i2s", r_a, e_r[0]);        cmp("R_lj", r_b, e_r[1]);
      cmp("cnt_i2s", cnt_a, e_cnt[0]);  cmp("cnt_lj", cnt_b, e_cnt[1]);
      if (vld_a === 1'b1) pulses_vld_a++;
      if (err_a === 1'b1) pulses_err_a++;
      if (vld_b === 1'b1) pulses_vld_b++;
      if (err_b === 1'b1) pulses_err_b++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic w, input logic [NL-1:0] d);
    ws = w; data = d;
    @(posedge clk);
    model_update(w, d);
    #1;
  endtask

  // One WS slot of n clocks; line values MSB first, idle bits driven as 1.
  task automatic slot(input logic w, input int n, input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                      input bit i2s_t, input int rst_at = -1, input int en_off = -1);
    logic [NL-1:0] d;
    int b;
    for (int p = 0; p < n; p++) begin
      b = i2s_t ? p - 1 : p;
      d = '1;
      if (b >= 0 && b < DW) begin
        d[0] = v0[DW-1-b];
        d[1] = v1[DW-1-b];
      end
      rst = (p == rst_at);
      en  = (p != en_off);
      step(w, d);
    end
    rst = 0; en = 1;
  endtask

  task automatic frame(input logic [DW-1:0] l0, input logic [DW-1:0] l1, input logic [DW-1:0] r0,
                       input logic [DW-1:0] r1, input bit i2s_t, input int rlen = SB);
    slot(1'b0, SB, l0, l1, i2s_t);
    slot(1'b1, rlen, r0, r1, i2s_t);
  endtask

  initial begin
    // Reset state
    rst = 1;
    repeat (3) step(1'b0, '0);
    rst = 0;
    cmp("rst_L", l_a, 48'h0); cmp("rst_R", r_b, 48'h0);
    cmp("rst_cnt", cnt_a, 16'h0); cmp("rst_vld", vld_a, 1'b0);

    // Startup with WS high: the rise alone must not start framing
    repeat (6) step(1'b1, '0);
    cmp("startup_cnt", cnt_a, 16'h0);

    // Clean I2S-timed frame
    frame(24'hABCDEF, 24'h800001, 24'h123456, 24'h7FFFFF, 1'b1);
    cmp("t1_L_i2s", l_a, 48'h800001_ABCDEF);
    cmp("t1_R_i2s", r_a, 48'h7FFFFF_123456);
    cmp("t1_cnt_i2s", cnt_a, 16'd1);
    cmp("t1_L_lj", l_b, 48'hC00000_D5E6F7);
    cmp("t1_R_lj", r_b, 48'hBFFFFF_891A2B);

    // Clean left-justified-timed frame
    frame(24'hABCDEF, 24'h800001, 24'h123456, 24'h7FFFFF, 1'b0);
    cmp("t2_L_lj", l_b, 48'h800001_ABCDEF);
    cmp("t2_R_lj", r_b, 48'h7FFFFF_123456);
    cmp("t2_cnt_lj", cnt_b, 16'd2);
    cmp("t2_L_i2s", l_a, 48'h000003_579BDF);
    cmp("t2_R_i2s", r_a, 48'hFFFFFF_2468AD);

    // Right slot cut to 20 clocks, then a clean frame starting on that fall
    frame(24'hABCDEF, 24'h800001, 24'h123456, 24'h7FFFFF, 1'b1, 20);
    cmp("t3_cnt_hold", cnt_a, 16'd2);
    cmp("t3_L_hold", l_a, 48'h000003_579BDF);
    frame(24'h5A5A5A, 24'h000000, 24'hA5A5A5, 24'hFFFFFF, 1'b1);
    cmp("t3_L_next", l_a, 48'h000000_5A5A5A);
    cmp("t3_R_next", r_a, 48'hFFFFFF_A5A5A5);
    cmp("t3_cnt_next", cnt_a, 16'd3);

    // WS stuck low for 40 clocks in LEFT, then recovery on a later fall
    slot(1'b0, 40, 24'h0, 24'h0, 1'b1);
    slot(1'b1, SB, 24'h0, 24'h0, 1'b1);
    cmp("t4_cnt_hold", cnt_a, 16'd3);
    frame(24'hABCDEF, 24'h800001, 24'h123456, 24'h7FFFFF, 1'b1);
    cmp("t4_cnt_rec", cnt_a, 16'd4);
    cmp("t4_L_rec", l_a, 48'h800001_ABCDEF);

    // Reset pulsed at position 10 of RIGHT
    slot(1'b0, SB, 24'h111111, 24'h222222, 1'b1);
    slot(1'b1, SB, 24'h333333, 24'h444444, 1'b1, 10);
    cmp("t6_rst_L", l_a, 48'h0); cmp("t6_rst_R", r_b, 48'h0);
    cmp("t6_rst_cnt", cnt_b, 16'h0);
    frame(24'h123456, 24'h654321, 24'hFEDCBA, 24'h0F0F0F, 1'b1);
    cmp("t6_cnt_after_rst", cnt_a, 16'd1);
    cmp("t6_L_after_rst", l_a, 48'h654321_123456);

    // en low for one clock mid-LEFT: frame dropped silently
    slot(1'b0, SB, 24'h111111, 24'h222222, 1'b1, -1, 10);
    slot(1'b1, SB, 24'h333333, 24'h444444, 1'b1);
    cmp("t6_en_cnt", cnt_a, 16'd1);
    frame(24'h000001, 24'h800000, 24'h00FF00, 24'hFF00FF, 1'b1);
    cmp("t6_en_cnt_next", cnt_a, 16'd2);
    cmp("t6_en_R", r_a, 48'hFF00FF_00FF00);
    slot(1'b0, 4, 24'h0, 24'h0, 1'b1);

    @(negedge clk);
    #1;
    cmp("pulses_vld_i2s", pulses_vld_a, 6);
    cmp("pulses_err_i2s", pulses_err_a, 2);
    cmp("pulses_vld_lj", pulses_vld_b, 6);
    cmp("pulses_err_lj", pulses_err_b, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
